dmem_arbiter: RTL and testbench



---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_arbiter_if.sv | 50 +++++
 rtl/rr_arbiter2.sv | 39 +++
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port ids
// and the byte-address to word-index helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_LSU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  function automatic logic [63:0] word_idx(input logic [63:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester handshakes plus the data-memory pins; the
// arbiter takes the slave side, requesters and memory the master side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req0_valid;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              resp0_valid;
  logic [DATA_W-1:0] resp0_rdata;
  logic              resp0_err;

  logic              req1_valid;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              resp1_valid;
  logic [DATA_W-1:0] resp1_rdata;
  logic              resp1_err;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, resp0_valid, resp0_rdata, resp0_err,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, resp1_valid, resp1_rdata, resp1_err,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, resp0_valid, resp0_rdata, resp0_err,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, resp1_valid, resp1_rdata, resp1_err,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input arbiter: round-robin on a last_grant register, or fixed priority
// to input 0. Grants only while en is high; last_grant moves on update.
module rr_arbiter2
  import dmem_pkg::*;
#(
  parameter int PRIO_MODE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (PRIO_MODE == 1 || last_grant == PORT_DMA) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Reset to the DMA side so the load/store port wins the first contest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= PORT_DMA;
    end else if (update) begin
      last_grant <= grant[1] ? PORT_DMA : PORT_LSU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the load/store unit and the
// DMA loader: accept, one access cycle, one registered response cycle.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int PRIO_MODE   = 0
) (
  input logic          clk,
  input logic          rst_n,
  dmem_arbiter_if.slave bus
);

  state_t            state;
  state_t            next_state;
  logic [1:0]        req_vec;
  logic [1:0]        grant;
  logic              grant_en;
  logic              accept;
  logic              sel_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_err;

  logic              lat_port;
  logic              lat_we;
  logic              lat_err;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] resp_rdata;

  // Ready is withheld during reset and for the whole ACCESS cycle.
  assign req_vec  = {bus.req1_valid, bus.req0_valid};
  assign grant_en = rst_n && (state != ACCESS);
  assign accept   = |grant;

  rr_arbiter2 #(.PRIO_MODE(PRIO_MODE)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_vec),
    .en     (grant_en),
    .update (accept),
    .grant  (grant)
  );

  assign sel_port  = grant[1] ? PORT_DMA : PORT_LSU;
  assign sel_we    = (sel_port == PORT_DMA) ? bus.req1_we    : bus.req0_we;
  assign sel_addr  = (sel_port == PORT_DMA) ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = (sel_port == PORT_DMA) ? bus.req1_wdata : bus.req0_wdata;
  assign sel_err   = (sel_addr[1:0] != 2'b00) ||
                     (word_idx(64'(sel_addr)) >= 64'(DEPTH_WORDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state      = state;
    bus.req0_ready  = grant[0];
    bus.req1_ready  = grant[1];
    bus.resp0_valid = 1'b0;
    bus.resp0_rdata = '0;
    bus.resp0_err   = 1'b0;
    bus.resp1_valid = 1'b0;
    bus.resp1_rdata = '0;
    bus.resp1_err   = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    case (state)
      IDLE: begin
        if (accept) next_state = ACCESS;
      end
      ACCESS: begin
        next_state = RESP;
        if (!lat_err) begin
          bus.mem_read  = !lat_we;
          bus.mem_write = lat_we;
          bus.mem_addr  = lat_addr;
          bus.mem_wdata = lat_wdata;
        end
      end
      RESP: begin
        next_state = accept ? ACCESS : IDLE;
        if (lat_port == PORT_LSU) begin
          bus.resp0_valid = 1'b1;
          bus.resp0_rdata = resp_rdata;
          bus.resp0_err   = lat_err;
        end else begin
          bus.resp1_valid = 1'b1;
          bus.resp1_rdata = resp_rdata;
          bus.resp1_err   = lat_err;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // A request accepted in RESP overwrites the latches only after the
  // current response has been presented, so one set of latches suffices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_port   <= PORT_LSU;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      resp_rdata <= '0;
    end else begin
      if (accept) begin
        lat_port  <= sel_port;
        lat_we    <= sel_we;
        lat_err   <= sel_err;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
      end
      if (state == ACCESS) begin
        resp_rdata <= (!lat_err && !lat_we) ? bus.mem_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: round-robin and fixed-priority instances share one
// stimulus stream and are checked against a transaction-level model.
module tb_dmem_arbiter;

  typedef struct packed {
    logic        v0;
    logic        we0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic        v1;
    logic        we1;
    logic [31:0] a1;
    logic [31:0] d1;
  } in_t;

  typedef struct packed {
    logic        r0;
    logic        r1;
    logic        rv0;
    logic [31:0] rd0;
    logic        re0;
    logic        rv1;
    logic [31:0] rd1;
    logic        re1;
    logic        mr;
    logic        mw;
    logic [31:0] ma;
    logic [31:0] md;
  } out_t;

  typedef struct packed {
    logic        v;
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    in_t  in;
    out_t exp;
    bit   adc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_rr ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_fp ();

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .PRIO_MODE(0)) dut_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_rr.slave)
  );

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .PRIO_MODE(1)) dut_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fp.slave)
  );

  function automatic logic [31:0] init_val(input logic [7:0] idx);
    return 32'hA500_0000 ^ ({24'h0, idx} * 32'h0101_0101);
  endfunction

  // Memory seen by each DUT; unwritten words read back their init pattern.
  logic [31:0] env_mem [2][256];
  bit          env_wr  [2][256];

  assign bus_rr.mem_rdata = bus_rr.mem_read ?
    (env_wr[0][bus_rr.mem_addr[9:2]] ? env_mem[0][bus_rr.mem_addr[9:2]] : init_val(bus_rr.mem_addr[9:2])) : 32'h0;
  assign bus_fp.mem_rdata = bus_fp.mem_read ?
    (env_wr[1][bus_fp.mem_addr[9:2]] ? env_mem[1][bus_fp.mem_addr[9:2]] : init_val(bus_fp.mem_addr[9:2])) : 32'h0;

  always @(posedge clk) begin
    if (bus_rr.mem_write) begin
      env_mem[0][bus_rr.mem_addr[9:2]] <= bus_rr.mem_wdata;
      env_wr[0][bus_rr.mem_addr[9:2]]  <= 1'b1;
    end
    if (bus_fp.mem_write) begin
      env_mem[1][bus_fp.mem_addr[9:2]] <= bus_fp.mem_wdata;
      env_wr[1][bus_fp.mem_addr[9:2]]  <= 1'b1;
    end
  end

  out_t obs [2];
  always_comb obs[0] = {bus_rr.req0_ready, bus_rr.req1_ready,
                        bus_rr.resp0_valid, bus_rr.resp0_rdata, bus_rr.resp0_err,
                        bus_rr.resp1_valid, bus_rr.resp1_rdata, bus_rr.resp1_err,
                        bus_rr.mem_read, bus_rr.mem_write, bus_rr.mem_addr, bus_rr.mem_wdata};
  always_comb obs[1] = {bus_fp.req0_ready, bus_fp.req1_ready,
                        bus_fp.resp0_valid, bus_fp.resp0_rdata, bus_fp.resp0_err,
                        bus_fp.resp1_valid, bus_fp.resp1_rdata, bus_fp.resp1_err,
                        bus_fp.mem_read, bus_fp.mem_write, bus_fp.mem_addr, bus_fp.mem_wdata};

  int          checks;
  int          errors;
  in_t         cur;
  txn_t        s1 [2];
  txn_t        s2 [2];
  logic        lastg [2];
  logic [1:0]  grant_seen [2];
  logic [31:0] ref_mem [2][256];
  vec_t        vec [11];

  function automatic in_t mk_in(input logic v0, we0, input logic [31:0] a0, d0,
                                input logic v1, we1, input logic [31:0] a1, d1);
    return {v0, we0, a0, d0, v1, we1, a1, d1};
  endfunction

  function automatic out_t mk_out(input logic r0, r1, rv0, input logic [31:0] rd0, input logic re0,
                                  input logic rv1, input logic [31:0] rd1, input logic re1,
                                  input logic mr, mw, input logic [31:0] ma, md);
    return {r0, r1, rv0, rd0, re0, rv1, rd1, re1, mr, mw, ma, md};
  endfunction

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'd256);
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 11);
    case (r)
      0:       return ({$urandom_range(0, 15)} << 2) | $urandom_range(1, 3);
      1:       return 32'h400 + ({$urandom_range(0, 63)} << 2);
      2:       return 32'hFFFF_FFFC;
      3:       return 32'h3FC;
      default: return {$urandom_range(0, 15)} << 2;
    endcase
  endfunction

  task automatic check_output(input string name, input int m, input logic [135:0] got,
                              input logic [135:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s dut%0d @%0t: got %0h expected %0h", name, m, $time, got, want);
    end
  endtask

  task automatic apply_stimulus(input in_t x);
    cur = x;
    bus_rr.req0_valid = x.v0; bus_rr.req0_we = x.we0; bus_rr.req0_addr = x.a0; bus_rr.req0_wdata = x.d0;
    bus_rr.req1_valid = x.v1; bus_rr.req1_we = x.we1; bus_rr.req1_addr = x.a1; bus_rr.req1_wdata = x.d1;
    bus_fp.req0_valid = x.v0; bus_fp.req0_we = x.we0; bus_fp.req0_addr = x.a0; bus_fp.req0_wdata = x.d0;
    bus_fp.req1_valid = x.v1; bus_fp.req1_we = x.we1; bus_fp.req1_addr = x.a1; bus_fp.req1_wdata = x.d1;
    #1;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      s1[m] = '0;
      s2[m] = '0;
      lastg[m] = 1'b1;
      grant_seen[m] = 2'b00;
    end
  endtask

  task automatic reset_check();
    for (int m = 0; m < 2; m++) check_output("reset_outputs", m, 136'(obs[m]), 136'(0));
  endtask

  // A new request can only be taken when the previous cycle took none; the
  // taken request strobes memory one cycle later and responds the cycle after.
  task automatic model_compare();
    out_t e;
    logic g0, g1;
    for (int m = 0; m < 2; m++) begin
      e = '0;
      g0 = 1'b0;
      g1 = 1'b0;
      if (!s1[m].v) begin
        if (cur.v0 && cur.v1) begin
          if (m == 1 || lastg[m]) g0 = 1'b1;
          else                    g1 = 1'b1;
        end else begin
          g0 = cur.v0;
          g1 = cur.v1;
        end
      end
      e.r0 = g0;
      e.r1 = g1;
      if (s1[m].v && !s1[m].err) begin
        e.mr = !s1[m].we;
        e.mw = s1[m].we;
        e.ma = s1[m].addr;
        e.md = s1[m].wdata;
      end
      if (s2[m].v) begin
        if (!s2[m].port) begin
          e.rv0 = 1'b1; e.rd0 = s2[m].rdata; e.re0 = s2[m].err;
        end else begin
          e.rv1 = 1'b1; e.rd1 = s2[m].rdata; e.re1 = s2[m].err;
        end
      end
      grant_seen[m] = {g1, g0};
      check_output("ready", m, 136'({obs[m].r0, obs[m].r1}), 136'({e.r0, e.r1}));
      check_output("resp", m,
        136'({obs[m].rv0, obs[m].rd0, obs[m].re0, obs[m].rv1, obs[m].rd1, obs[m].re1}),
        136'({e.rv0, e.rd0, e.re0, e.rv1, e.rd1, e.re1}));
      check_output("mem_strobe", m, 136'({obs[m].mr, obs[m].mw}), 136'({e.mr, e.mw}));
      if (!(s1[m].v && s1[m].err))
        check_output("mem_bus", m, 136'({obs[m].ma, obs[m].md}), 136'({e.ma, e.md}));
    end
  endtask

  task automatic model_advance();
    txn_t t;
    for (int m = 0; m < 2; m++) begin
      t = s1[m];
      t.rdata = '0;
      if (t.v && !t.err) begin
        if (t.we) ref_mem[m][t.addr[9:2]] = t.wdata;
        else      t.rdata = ref_mem[m][t.addr[9:2]];
      end
      s2[m] = t;
      s1[m] = '0;
      if (grant_seen[m] != 2'b00) begin
        s1[m].v     = 1'b1;
        s1[m].port  = grant_seen[m][1];
        s1[m].we    = grant_seen[m][1] ? cur.we1 : cur.we0;
        s1[m].addr  = grant_seen[m][1] ? cur.a1  : cur.a0;
        s1[m].wdata = grant_seen[m][1] ? cur.d1  : cur.d0;
        s1[m].err   = addr_err(s1[m].addr);
        lastg[m]    = grant_seen[m][1];
      end
    end
  endtask

  task automatic step(input in_t x);
    apply_stimulus(x);
    model_compare();
    model_advance();
  endtask

  task automatic rand_cycles(input int n, input bit both);
    in_t x;
    for (int i = 0; i < n; i++) begin
      x = cur;
      if (!x.v0 || grant_seen[0][0]) begin
        x.v0 = both || ($urandom_range(0, 2) != 0);
        x.we0 = 1'($urandom_range(0, 1));
        x.a0 = rand_addr();
        x.d0 = $urandom;
      end
      if (!x.v1 || grant_seen[0][1]) begin
        x.v1 = both || ($urandom_range(0, 2) != 0);
        x.we1 = 1'($urandom_range(0, 1));
        x.a1 = rand_addr();
        x.d1 = $urandom;
      end
      step(x);
      if (both) check_output("fp_port1_blocked", 1, 136'(bus_fp.req1_ready), 136'(0));
      @(negedge clk);
    end
  endtask

  initial begin
    out_t mask;
    in_t  idle;
    in_t  hold;
    checks = 0;
    errors = 0;
    idle = '0;
    for (int m = 0; m < 2; m++)
      for (int w = 0; w < 256; w++) ref_mem[m][w] = init_val(8'(w));

    vec[0]  = '{mk_in(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0};
    vec[1]  = '{idle, mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h10, 32'hDEADBEEF), 1'b0};
    vec[2]  = '{mk_in(1, 0, 32'h10, 0, 0, 0, 0, 0), mk_out(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0};
    vec[3]  = '{idle, mk_out(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h10, 0), 1'b0};
    vec[4]  = '{idle, mk_out(0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0};
    vec[5]  = '{mk_in(0, 0, 0, 0, 1, 0, 32'h402, 0), mk_out(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0};
    vec[6]  = '{mk_in(0, 0, 0, 0, 1, 0, 32'h400, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1};
    vec[7]  = '{mk_in(0, 0, 0, 0, 1, 0, 32'h400, 0), mk_out(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), 1'b0};
    vec[8]  = '{idle, mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1};
    vec[9]  = '{idle, mk_out(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), 1'b0};
    vec[10] = '{idle, mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0};

    apply_stimulus(idle);
    reset_check();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      step(vec[i].in);
      mask = '1;
      if (vec[i].adc) begin
        mask.ma = '0;
        mask.md = '0;
      end
      for (int m = 0; m < 2; m++)
        check_output($sformatf("vec%0d", i), m, 136'(obs[m] & mask), 136'(vec[i].exp & mask));
      @(negedge clk);
    end

    // Store accepted, then reset lands in the middle of its ACCESS cycle.
    step(mk_in(1, 1, 32'h20, 32'h12345678, 0, 0, 0, 0));
    @(negedge clk);
    apply_stimulus(idle);
    model_compare();
    #2;
    hold = mk_in(1, 0, 32'h20, 0, 1, 1, 32'h24, 32'hCAFEF00D);
    apply_stimulus(hold);
    rst_n = 1'b0;
    #1;
    reset_check();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(hold);
    model_compare();
    for (int m = 0; m < 2; m++)
      check_output("post_reset_grant", m, 136'({obs[m].r0, obs[m].r1}), 136'(2'b10));
    model_advance();
    @(negedge clk);

    // DMA keeps its request up through ACCESS and is taken in RESP.
    hold = mk_in(0, 0, 0, 0, 1, 1, 32'h24, 32'hCAFEF00D);
    step(hold);
    @(negedge clk);
    step(hold);
    check_output("resp_accept_dma", 0, 136'(bus_rr.req1_ready), 136'(1));
    @(negedge clk);
    step(idle);
    @(negedge clk);
    step(idle);
    @(negedge clk);
    step(idle);
    @(negedge clk);

    rand_cycles(16, 1'b1);
    rand_cycles(600, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
